bsg_fifo_1r1w_small_cnt: RTL

Parametrised single-clock FIFO with width_p bits and els_p entries. It is the multi-entry successor of the one-element FIFO and keeps the same handshake:
- Input side is ready-then-valid: an element is accepted when v_i & ready_o.
- Output side is valid-yumi.
It adds an occupancy count, an almost-full flag and an optional same-cycle enqueue-on-full mode. It sits between pipeline stages in the dataflow library as a general elastic buffer.

---
 rtl/bsg_fifo_1r1w_small_cnt.sv | 84 ++++++++
 1 files changed

// File: rtl/bsg_fifo_1r1w_small_cnt.sv
// Purpose: single-clock elastic FIFO (width_p x els_p) with occupancy count and almost-full flag.
// Latency: one cycle from an accepted enqueue to v_o/data_o; no input-to-output bypass.
// Backpressure: ready_o drops when full; with ready_thru_p=1 a same-cycle yumi_i reopens it.
module bsg_fifo_1r1w_small_cnt #(
    parameter int width_p        = 32,
    parameter int els_p          = 4,
    parameter int ready_thru_p   = 0,
    parameter int afull_thresh_p = els_p - 1,
    localparam int ptr_width_lp  = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_width_lp  = $clog2(els_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic [width_p-1:0]      data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    input  logic                    yumi_i,
    output logic [cnt_width_lp-1:0] count_o,
    output logic                    almost_full_o
);

    localparam logic [ptr_width_lp-1:0] last_ptr_lp  = ptr_width_lp'(els_p - 1);
    localparam logic [cnt_width_lp-1:0] els_cnt_lp   = cnt_width_lp'(els_p);
    localparam logic [cnt_width_lp-1:0] afull_cnt_lp = cnt_width_lp'(afull_thresh_p);

    logic [ptr_width_lp-1:0] rptr, wptr;
    logic [cnt_width_lp-1:0] count;
    logic                    full, empty, enq, deq;

    // Explicit wrap so non-power-of-two depths never index past the last slot.
    function automatic logic [ptr_width_lp-1:0] ptr_next(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == els_cnt_lp);
    assign empty   = (count == '0);
    assign ready_o = ~full | ((ready_thru_p != 0) & yumi_i);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i;

    assign v_o           = ~empty;
    assign count_o       = count;
    assign almost_full_o = (count >= afull_cnt_lp);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= ptr_next(wptr);
            if (deq) rptr <= ptr_next(rptr);
            if (enq & ~deq)
                count <= count + 1'b1;
            else if (deq & ~enq)
                count <= count - 1'b1;
        end
    end

    // Storage is intentionally unreset; data_o is meaningless while v_o is low.
    if (els_p == 1) begin : g_one
        logic [width_p-1:0] mem_r;
        always_ff @(posedge clk_i) begin
            if (enq) mem_r <= data_i;
        end
        assign data_o = mem_r;
    end else begin : g_many
        logic [width_p-1:0] mem_r [els_p];
        always_ff @(posedge clk_i) begin
            if (enq) mem_r[wptr] <= data_i;
        end
        assign data_o = mem_r[rptr];
    end

`ifndef SYNTHESIS
    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && !v_o))
        else $error("yumi_i asserted while fifo empty");
    a_count_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i) count <= els_cnt_lp)
        else $error("fifo count exceeds depth");
`endif

endmodule
